rvi_control_unit: RTL

- Multi-cycle sequencing FSM for the RV32I core.
- Drives fetch handshake, ALU start, memory request and register/PC write enables from decoded opcode_t and {funct7,funct3} fields of rvi_pkg.
- Sits between fetch unit, ALU, LSU and register file; one instruction in flight at a time.
- Also keeps a retired-instruction counter.

---
 rtl/rvi_control_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/rvi_control_unit.sv
// Multi-cycle RV32I sequencing FSM: fetch handshake, ALU start, LSU request, RF/PC write enables.
// Optional RVI_CONTROL_ILLEGAL_TRAP_EN adds a trap output and halts the core on an illegal instruction.
package rvi_pkg;
    typedef enum logic [6:0] {
        LOAD       = 7'b0000011,
        MISC_MEM   = 7'b0001111,
        OP_IMM     = 7'b0010011,
        AUIPC      = 7'b0010111,
        STORE      = 7'b0100011,
        OP         = 7'b0110011,
        LUI        = 7'b0110111,
        BRANCH     = 7'b1100011,
        JALR       = 7'b1100111,
        JAL        = 7'b1101111,
        SYSTEM     = 7'b1110011,
        RESERVED_4 = 7'b1111111
    } opcode_t;

    typedef enum logic [2:0] {
        BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101, BLTU = 3'b110, BGEU = 3'b111
    } branch_funct_t;

    typedef enum logic [2:0] {
        LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101
    } load_funct_t;

    typedef enum logic [2:0] {
        SB = 3'b000, SH = 3'b001, SW = 3'b010
    } store_funct_t;

    // {funct7, funct3}
    typedef enum logic [9:0] {
        ADDI  = 10'b0000000_000, SLLI = 10'b0000000_001, SLTI = 10'b0000000_010,
        SLTIU = 10'b0000000_011, XORI = 10'b0000000_100, SRLI = 10'b0000000_101,
        SRAI  = 10'b0100000_101, ORI  = 10'b0000000_110, ANDI = 10'b0000000_111
    } op_imm_funct_t;

    typedef enum logic [9:0] {
        ADD  = 10'b0000000_000, SUB = 10'b0100000_000, SLL = 10'b0000000_001,
        SLT  = 10'b0000000_010, SLTU = 10'b0000000_011, XOR = 10'b0000000_100,
        SRL  = 10'b0000000_101, SRA = 10'b0100000_101, OR = 10'b0000000_110,
        AND  = 10'b0000000_111
    } op_funct_t;
endpackage

module rvi_control_unit
    import rvi_pkg::*;
#(
    parameter int INSTRET_WIDTH = 32,
    parameter int MEM_TIMEOUT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [6:0]               opcode,
    input  logic [9:0]               funct,
    output logic                     fetch_req,
    output logic                     alu_start,
    input  logic                     alu_done,
    input  logic                     branch_taken,
    output logic                     mem_req,
    output logic                     mem_we,
    input  logic                     mem_ack,
    output logic                     rd_en,
    output logic                     pc_en,
    output logic [1:0]               pc_sel,
    output logic                     mem_err,
`ifdef RVI_CONTROL_ILLEGAL_TRAP_EN
    output logic                     trap,
`endif
    output logic [INSTRET_WIDTH-1:0] instret
);

`ifdef RVI_CONTROL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int TW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

    state_t          state, state_nxt;
    logic [6:0]      op_q;
    logic [9:0]      funct_q;
    logic            exec_first, taken_q, timeout_q, halted;
    logic [TW-1:0]   mem_cnt;
    logic            legal, no_exec, is_mem, is_store, writes_rd, mem_to;

    // Classification of the latched instruction; stable from DECODE through WB.
    always_comb begin
        legal     = 1'b0;
        no_exec   = 1'b0;
        is_mem    = 1'b0;
        is_store  = 1'b0;
        writes_rd = 1'b0;
        case (op_q)
            LUI:             begin legal = 1'b1; no_exec = 1'b1; writes_rd = 1'b1; end
            AUIPC, JAL, JALR: begin legal = 1'b1; writes_rd = 1'b1; end
            BRANCH:          legal = funct_q[2:0] inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
            LOAD:            begin
                legal     = funct_q[2:0] inside {LB, LH, LW, LBU, LHU};
                is_mem    = 1'b1;
                writes_rd = 1'b1;
            end
            STORE:           begin
                legal    = funct_q[2:0] inside {SB, SH, SW};
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            // only the shift-immediates carry a meaningful funct7
            OP_IMM:          begin
                legal     = (funct_q[2:0] == 3'b001 || funct_q[2:0] == 3'b101) ?
                            (funct_q inside {SLLI, SRLI, SRAI}) : 1'b1;
                writes_rd = 1'b1;
            end
            OP:              begin
                legal     = funct_q inside {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND};
                writes_rd = 1'b1;
            end
            MISC_MEM, SYSTEM: begin legal = 1'b1; no_exec = 1'b1; end
            default:         ;
        endcase
    end

    assign mem_to = (MEM_TIMEOUT > 0) && !mem_ack && (mem_cnt == TW'(TO_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        inst_ready = 1'b0;
        fetch_req  = 1'b0;
        alu_start  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        rd_en      = 1'b0;
        pc_en      = 1'b0;
        pc_sel     = 2'd0;
        case (state)
            IDLE:   if (!halted) state_nxt = FETCH;
            FETCH:  begin
                fetch_req  = 1'b1;
                inst_ready = 1'b1;
                if (inst_valid) state_nxt = DECODE;
            end
            DECODE: state_nxt = (legal && !no_exec) ? EXEC : WB;
            EXEC:   begin
                alu_start = exec_first;
                if (alu_done) state_nxt = is_mem ? MEM : WB;
            end
            MEM:    begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ack || mem_to) state_nxt = WB;
            end
            WB:     begin
                if (!legal && TRAP_EN) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = FETCH;
                    pc_en     = 1'b1;
                    rd_en     = legal && writes_rd && !timeout_q;
                    if (legal) begin
                        if (op_q == JAL || (op_q == BRANCH && taken_q)) pc_sel = 2'd1;
                        else if (op_q == JALR)                          pc_sel = 2'd2;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RVI_CONTROL_ILLEGAL_TRAP_EN
    assign trap = (state == WB) && !legal;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= '0;
            funct_q    <= '0;
            exec_first <= 1'b0;
            taken_q    <= 1'b0;
            timeout_q  <= 1'b0;
            halted     <= 1'b0;
            mem_cnt    <= '0;
            mem_err    <= 1'b0;
            instret    <= '0;
        end else begin
            if (state == FETCH && inst_valid) begin
                op_q      <= opcode;
                funct_q   <= funct;
                taken_q   <= 1'b0;
                timeout_q <= 1'b0;
            end
            exec_first <= (state == DECODE);
            if (state == EXEC && alu_done) taken_q <= branch_taken;
            mem_cnt <= (state == MEM) ? mem_cnt + 1'b1 : '0;
            if (state == MEM && mem_to) begin
                timeout_q <= 1'b1;
                mem_err   <= 1'b1;
            end
            if (state == WB && (legal || !TRAP_EN)) instret <= instret + 1'b1;
            if (state == WB && !legal && TRAP_EN) halted <= 1'b1;
        end
    end

endmodule
